// File: rtl/regfile_2w2r_if.sv
// Bus bundle for the two-write, two-read register file: write ports, read ports
// and the sweep-clear handshake.
interface regfile_2w2r_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [DATA_W-1:0] wr_data0;
    logic              wr_en1;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data1;
    logic [ADDR_W-1:0] rd_addr0;
    logic [DATA_W-1:0] rd_data0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output wr_en0, wr_addr0, wr_data0,
        output wr_en1, wr_addr1, wr_data1,
        output rd_addr0, rd_addr1, clr_req,
        input  rd_data0, rd_data1, clr_busy, clr_done
    );

    modport slave (
        input  wr_en0, wr_addr0, wr_data0,
        input  wr_en1, wr_addr1, wr_data1,
        input  rd_addr0, rd_addr1, clr_req,
        output rd_data0, rd_data1, clr_busy, clr_done
    );
endinterface

// File: rtl/regfile_2w2r.sv
// Parametrised 2-write/2-read register file with a DEPTH-cycle sweep-clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching reads.
module regfile_2w2r #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    regfile_2w2r_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_sweepPtr;
    logic              r_clrBusy;
    logic              r_clrDone;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_idle;
    logic              w_wrOk0;
    logic              w_wrOk1;
    logic [ADDR_W-1:0] w_rdAddr [2];
    logic [DATA_W-1:0] w_rdData [2];

    assign w_idle  = (r_state == IDLE);
    assign w_wrOk0 = w_idle && bus.wr_en0 && !(ZERO_REG && (bus.wr_addr0 == '0));
    assign w_wrOk1 = w_idle && bus.wr_en1 && !(ZERO_REG && (bus.wr_addr1 == '0));

    // Port 1 is assigned after port 0 so it wins when both hit the same address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sweepPtr <= '0;
            r_clrBusy  <= 1'b0;
            r_clrDone  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wrOk0) begin
                        r_mem[bus.wr_addr0] <= bus.wr_data0;
                    end
                    if (w_wrOk1) begin
                        r_mem[bus.wr_addr1] <= bus.wr_data1;
                    end
                    if (bus.clr_req) begin
                        r_state    <= SWEEP;
                        r_sweepPtr <= '0;
                        r_clrBusy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    r_mem[r_sweepPtr] <= '0;
                    r_sweepPtr        <= r_sweepPtr + ADDR_W'(1);
                    if (r_sweepPtr == LAST_IDX) begin
                        r_state   <= DONE;
                        r_clrDone <= 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_clrBusy <= 1'b0;
                    r_clrDone <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_clrBusy <= 1'b0;
                    r_clrDone <= 1'b0;
                end
            endcase
        end
    end

    assign w_rdAddr[0] = bus.rd_addr0;
    assign w_rdAddr[1] = bus.rd_addr1;

    // w_wrOk* already excludes non-IDLE states and the hardwired zero register.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdData[p] = r_mem[w_rdAddr[p]];
`ifdef REGFILE_BYPASS_EN
            if (w_wrOk1 && (bus.wr_addr1 == w_rdAddr[p])) begin
                w_rdData[p] = bus.wr_data1;
            end else if (w_wrOk0 && (bus.wr_addr0 == w_rdAddr[p])) begin
                w_rdData[p] = bus.wr_data0;
            end
`endif
            if (reset || (ZERO_REG && (w_rdAddr[p] == '0))) begin
                w_rdData[p] = '0;
            end
        end
    end

    assign bus.rd_data0 = w_rdData[0];
    assign bus.rd_data1 = w_rdData[1];
    assign bus.clr_busy = r_clrBusy;
    assign bus.clr_done = r_clrDone;
endmodule

// File: tb/tb_regfile_2w2r.sv
// Self-checking bench for regfile_2w2r: reference array model feeding a queue of
// expected read values, plus cycle-level observation of the sweep-clear handshake.
module tb_regfile_2w2r;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 32;
    localparam bit ZERO_REG = 1'b1;

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] expVal;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    regfile_2w2r_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_2w2r #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] model [DEPTH];
    exp_t              expQ [$];
    int                assertCount = 0;
    int                failCount   = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Write ports are driven just after a falling edge; the model commits on the rising edge.
    task automatic applyStimulus(input logic en0, input logic [ADDR_W-1:0] a0,
                                 input logic [DATA_W-1:0] d0, input logic en1,
                                 input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        bus.wr_en0 = en0; bus.wr_addr0 = a0; bus.wr_data0 = d0;
        bus.wr_en1 = en1; bus.wr_addr1 = a1; bus.wr_data1 = d1;
        @(posedge clk);
        if (en0 && !(ZERO_REG && a0 == '0)) model[a0] = d0;
        if (en1 && !(ZERO_REG && a1 == '0)) model[a1] = d1;
        @(negedge clk);
        bus.wr_en0 = 1'b0;
        bus.wr_en1 = 1'b0;
    endtask

    task automatic checkReadPair(input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] e0,
                                 input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] e1,
                                 input string tag);
        exp_t e;
        bus.rd_addr0 = a0;
        bus.rd_addr1 = a1;
        e.tag = $sformatf("%s rd0 addr %0d", tag, a0); e.expVal = e0; expQ.push_back(e);
        e.tag = $sformatf("%s rd1 addr %0d", tag, a1); e.expVal = e1; expQ.push_back(e);
        #1;
        e = expQ.pop_front();
        checkOutput(e.tag, bus.rd_data0, e.expVal);
        e = expQ.pop_front();
        checkOutput(e.tag, bus.rd_data1, e.expVal);
    endtask

    task automatic readPair(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                            input string tag);
        checkReadPair(a0, model[a0], a1, model[a1], tag);
    endtask

    task automatic readAll(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            readPair(ADDR_W'(k), ADDR_W'(k + 1), tag);
        end
    endtask

    // Edge e is the e-th rising edge after the request edge; observation follows each edge.
    task automatic runSweep(input int holdEdges, input int numEdges, input bit doWrites,
                            output int busyRise, output int busyCount, output int doneCount,
                            output int doneEdge0, output int doneEdge1);
        busyRise = -1; busyCount = 0; doneCount = 0; doneEdge0 = -1; doneEdge1 = -1;
        bus.clr_req = 1'b1;
        for (int e = 0; e < numEdges; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e >= holdEdges) bus.clr_req = 1'b0;
            bus.wr_en0 = 1'b0;
            if (doWrites && (e == 10 || e == 32)) begin
                bus.wr_en0   = 1'b1;
                bus.wr_addr0 = (e == 10) ? ADDR_W'(31) : ADDR_W'(5);
                bus.wr_data0 = 32'hFFFF;
            end
            if (doWrites && e == 5) begin
                checkReadPair(ADDR_W'(4), '0, ADDR_W'(20), model[20], "live sweep");
            end
            if (bus.clr_busy) begin
                busyCount++;
                if (busyRise < 0) busyRise = e;
            end
            if (bus.clr_done) begin
                doneCount++;
                if (doneEdge0 < 0) doneEdge0 = e;
                else if (doneEdge1 < 0) doneEdge1 = e;
            end
        end
        bus.clr_req = 1'b0;
        bus.wr_en0  = 1'b0;
    endtask

    initial begin
        int busyRise, busyCount, doneCount, doneEdge0, doneEdge1, doneSeen;

        reset = 1'b1;
        bus.wr_en0 = 1'b0; bus.wr_addr0 = '0; bus.wr_data0 = '0;
        bus.wr_en1 = 1'b0; bus.wr_addr1 = '0; bus.wr_data1 = '0;
        bus.rd_addr0 = '0; bus.rd_addr1 = '0; bus.clr_req = 1'b0;
        clearModel();

        repeat (2) @(negedge clk);
        checkOutput("reset clr_busy", 32'(bus.clr_busy), 0);
        checkOutput("reset clr_done", 32'(bus.clr_done), 0);
        readPair(ADDR_W'(1), ADDR_W'(31), "reset");
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b1, ADDR_W'(k), DATA_W'(10 * k), 1'b0, '0, '0);
        end
        readAll("fill");

        applyStimulus(1'b0, '0, '0, 1'b1, '0, 32'h1234);
        readPair('0, ADDR_W'(2), "zero reg");

        applyStimulus(1'b1, ADDR_W'(3), 32'hAAAA, 1'b1, ADDR_W'(4), 32'h5555);
        applyStimulus(1'b1, ADDR_W'(7), 32'h1111, 1'b1, ADDR_W'(7), 32'h2222);
        checkReadPair(ADDR_W'(3), 32'hAAAA, ADDR_W'(4), 32'h5555, "dual write");
        checkReadPair(ADDR_W'(7), 32'h2222, ADDR_W'(7), 32'h2222, "same addr");

        bus.wr_en0 = 1'b1; bus.wr_addr0 = ADDR_W'(9); bus.wr_data0 = 32'hDEAD;
`ifdef REGFILE_BYPASS_EN
        checkReadPair(ADDR_W'(9), 32'hDEAD, ADDR_W'(8), 32'd80, "bypass");
`else
        checkReadPair(ADDR_W'(9), 32'd90, ADDR_W'(8), 32'd80, "no bypass");
`endif
        @(posedge clk);
        model[9] = 32'hDEAD;
        @(negedge clk);
        bus.wr_en0 = 1'b0;
        readPair(ADDR_W'(9), ADDR_W'(10), "after bypass edge");

        runSweep(0, 40, 1'b1, busyRise, busyCount, doneCount, doneEdge0, doneEdge1);
        clearModel();
        checkOutput("sweep busy rise edge", busyRise, 0);
        checkOutput("sweep busy cycles", busyCount, 33);
        checkOutput("sweep done count", doneCount, 1);
        checkOutput("sweep done edge", doneEdge0, 32);
        readAll("after sweep");

        for (int k = 1; k < DEPTH; k += 2) begin
            applyStimulus(1'b1, ADDR_W'(k), DATA_W'(32'h100 + k),
                          1'b1, ADDR_W'(k + 1), DATA_W'(32'h200 + k));
        end
        readPair(ADDR_W'(12), ADDR_W'(25), "refill");
        bus.clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("mid sweep busy", 32'(bus.clr_busy), 1);
        reset = 1'b1;
        clearModel();
        #1;
        checkOutput("reset mid sweep busy", 32'(bus.clr_busy), 0);
        checkOutput("reset mid sweep done", 32'(bus.clr_done), 0);
        readPair(ADDR_W'(15), ADDR_W'(30), "in reset");
        @(negedge clk);
        reset = 1'b0;
        doneSeen = 0;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            if (bus.clr_done || bus.clr_busy) doneSeen++;
        end
        checkOutput("no done after reset", doneSeen, 0);
        readAll("after reset sweep");

        runSweep(34, 80, 1'b0, busyRise, busyCount, doneCount, doneEdge0, doneEdge1);
        checkOutput("b2b busy cycles", busyCount, 66);
        checkOutput("b2b done count", doneCount, 2);
        checkOutput("b2b first done", doneEdge0, 32);
        checkOutput("b2b done spacing", doneEdge1 - doneEdge0, 34);
        checkOutput("b2b busy after", 32'(bus.clr_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
